// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: source-select codes, FSM states
// and default widths.
package writeback_stage_pkg;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_REG_ADDR_W = 3;
    localparam int DEF_CNT_W      = 32;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MEM = 2'd1;
    localparam logic [1:0] SRC_PC2 = 2'd2;
    localparam logic [1:0] SRC_IMM = 2'd3;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FULL     = 2'd1,
        WAIT_MEM = 2'd2,
        HALTED   = 2'd3
    } wb_state_e;
endpackage

// File: rtl/writeback_stage_if.sv
// MEM -> WB handshake, register-file write port and bypass-hold signals.
interface writeback_stage_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 32
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_src_sel;
    logic [DATA_W-1:0]     in_alu_result;
    logic [DATA_W-1:0]     in_pc_plus_two;
    logic [DATA_W-1:0]     in_imm;
    logic                  in_reg_write;
    logic [REG_ADDR_W-1:0] in_write_reg;
    logic                  in_is_load;
    logic                  in_halt;
    logic [DATA_W-1:0]     mem_data;
    logic                  mem_data_valid;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0]     wb_data;
    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_reg;
    logic [DATA_W-1:0]     fwd_data;
    logic                  halted;
    logic [CNT_W-1:0]      retire_cnt;

    modport master (
        output in_valid, in_src_sel, in_alu_result, in_pc_plus_two, in_imm,
               in_reg_write, in_write_reg, in_is_load, in_halt, mem_data, mem_data_valid,
        input  in_ready, wb_en, wb_reg, wb_data, fwd_valid, fwd_reg, fwd_data,
               halted, retire_cnt
    );

    modport slave (
        input  in_valid, in_src_sel, in_alu_result, in_pc_plus_two, in_imm,
               in_reg_write, in_write_reg, in_is_load, in_halt, mem_data, mem_data_valid,
        output in_ready, wb_en, wb_reg, wb_data, fwd_valid, fwd_reg, fwd_data,
               halted, retire_cnt
    );
endinterface

// File: rtl/writeback_stage_src_mux.sv
// Combinational 4:1 writeback source select; also used by the forwarding unit.
module wb_src_mux
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] alu,
    input  logic [DATA_W-1:0] mem,
    input  logic [DATA_W-1:0] pc2,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] out
);
    always_comb begin
        out = alu;
        case (sel)
            SRC_ALU: out = alu;
            SRC_MEM: out = mem;
            SRC_PC2: out = pc2;
            SRC_IMM: out = imm;
            default: out = alu;
        endcase
    end
endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with late load data, one-cycle bypass hold,
// halt retirement and retired-instruction counter.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter bit FWD_HOLD   = 1'b1
) (
    input logic clk,
    input logic rst,
    writeback_stage_if.slave bus
);
    wb_state_e             state;
    logic                  inReady, accept;
    logic [1:0]            effSel;
    logic [DATA_W-1:0]     selData, wbDataQ, fwdDataQ;
    logic [REG_ADDR_W-1:0] pendReg, wbRegQ, fwdRegQ;
    logic                  pendWe, pendHalt, fullHalt;
    logic                  wbEnQ, fwdValidQ, haltedQ;
    logic [CNT_W-1:0]      retireCnt;

    assign inReady = (state == EMPTY) || (state == FULL);
    assign accept  = bus.in_valid && inReady;
    // Loads always take memory data, whatever the encoded source says.
    assign effSel  = bus.in_is_load ? SRC_MEM : bus.in_src_sel;

    wb_src_mux #(.DATA_W(DATA_W)) uSrcMux (
        .sel (effSel),
        .alu (bus.in_alu_result),
        .mem (bus.mem_data),
        .pc2 (bus.in_pc_plus_two),
        .imm (bus.in_imm),
        .out (selData)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            pendReg   <= '0;
            pendWe    <= 1'b0;
            pendHalt  <= 1'b0;
            fullHalt  <= 1'b0;
            wbEnQ     <= 1'b0;
            wbRegQ    <= '0;
            wbDataQ   <= '0;
            fwdValidQ <= 1'b0;
            fwdRegQ   <= '0;
            fwdDataQ  <= '0;
            haltedQ   <= 1'b0;
            retireCnt <= '0;
        end else begin
            wbEnQ     <= 1'b0;
            fwdValidQ <= 1'b0;
            if (state == FULL) begin
                retireCnt <= retireCnt + 1'b1;
                if (wbEnQ) begin
                    fwdValidQ <= 1'b1;
                    fwdRegQ   <= wbRegQ;
                    fwdDataQ  <= wbDataQ;
                end
            end
            case (state)
                EMPTY, FULL: begin
                    // Anything accepted alongside a retiring halt is dropped.
                    if (state == FULL && fullHalt) begin
                        state   <= HALTED;
                        haltedQ <= 1'b1;
                    end else if (accept && bus.in_is_load && !bus.mem_data_valid) begin
                        pendReg  <= bus.in_write_reg;
                        pendWe   <= bus.in_reg_write;
                        pendHalt <= bus.in_halt;
                        state    <= WAIT_MEM;
                    end else if (accept) begin
                        wbEnQ    <= bus.in_reg_write;
                        wbRegQ   <= bus.in_write_reg;
                        wbDataQ  <= selData;
                        fullHalt <= bus.in_halt;
                        state    <= FULL;
                    end else begin
                        state <= EMPTY;
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_data_valid) begin
                        wbEnQ    <= pendWe;
                        wbRegQ   <= pendReg;
                        wbDataQ  <= bus.mem_data;
                        fullHalt <= pendHalt;
                        state    <= FULL;
                    end
                end
                HALTED:  state <= HALTED;
                default: state <= EMPTY;
            endcase
        end
    end

    assign bus.in_ready   = inReady;
    assign bus.wb_en      = wbEnQ;
    assign bus.wb_reg     = wbRegQ;
    assign bus.wb_data    = wbDataQ;
    assign bus.halted     = haltedQ;
    assign bus.retire_cnt = retireCnt;

    generate
        if (FWD_HOLD) begin : gFwd
            assign bus.fwd_valid = fwdValidQ;
            assign bus.fwd_reg   = fwdRegQ;
            assign bus.fwd_data  = fwdDataQ;
        end else begin : gNoFwd
            assign bus.fwd_valid = 1'b0;
            assign bus.fwd_reg   = '0;
            assign bus.fwd_data  = '0;
        end
    endgenerate
endmodule
